// File: rtl/shared_fsb_tx_arbiter.sv
// shared_fsb_tx_arbiter
// ---------------------
// Merges packets from num_req_p requesters onto one FSB master port. A
// round-robin arbiter picks one eligible requester per cycle. A single output
// register holds the packet until the FSB accepts it. Each requester has a
// credit counter that limits its outstanding packets to max_credits_p. Credits
// come back one at a time through credit_v_i/credit_id_i.
//
// Ports
//   clk_i         : clock; all logic on its rising edge
//   reset_n_i     : synchronous active-low reset
//   req_v_i       : per-requester packet valid
//   req_data_i    : per-requester packet; requester i at [i*fsb_width_p +: fsb_width_p]
//   req_r_o       : per-requester ready; at most one bit set per cycle
//   m_fsb_v_o     : FSB master valid
//   m_fsb_data_o  : FSB master packet
//   m_fsb_r_i     : FSB master ready
//   m_fsb_src_o   : requester index of the packet on m_fsb_data_o
//   credit_v_i    : one credit returned this cycle
//   credit_id_i   : requester that receives the returned credit
//   credit_err_o  : sticky error; set on credit underflow or an out-of-range id
module shared_fsb_tx_arbiter #(
  parameter int num_req_p     = 4,
  parameter int fsb_width_p   = 80,
  parameter int max_credits_p = 8,
  parameter int id_width_lp   = $clog2(num_req_p)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_req_p-1:0]             req_v_i,
  input  logic [num_req_p*fsb_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]             req_r_o,
  output logic                             m_fsb_v_o,
  output logic [fsb_width_p-1:0]           m_fsb_data_o,
  input  logic                             m_fsb_r_i,
  output logic [id_width_lp-1:0]           m_fsb_src_o,
  input  logic                             credit_v_i,
  input  logic [id_width_lp-1:0]           credit_id_i,
  output logic                             credit_err_o
);

  localparam int cnt_width_lp = $clog2(max_credits_p + 1);
  localparam int id_space_lp  = 1 << id_width_lp;

  // Output register and arbitration state
  logic                   out_v_reg;
  logic [fsb_width_p-1:0] out_data_reg;
  logic [id_width_lp-1:0] out_src_reg;
  logic [id_width_lp-1:0] last_grant_reg;
  logic                   err_reg;
  logic                   err_next;

  // Outstanding-packet counters
  logic [cnt_width_lp-1:0] cnt_reg  [num_req_p];
  logic [cnt_width_lp-1:0] cnt_next [num_req_p];

  logic [fsb_width_p-1:0] req_data_arr [num_req_p];
  logic                   load_en;
  logic [num_req_p-1:0]   eligible;
  logic                   found;
  logic [id_width_lp-1:0] winner;
  logic [id_width_lp-1:0] scan_idx;
  logic                   xfer;
  logic [id_space_lp-1:0] id_ok_mask;
  logic                   id_ok;
  logic [num_req_p-1:0]   inc;
  logic [num_req_p-1:0]   dec;
  logic [num_req_p-1:0]   underflow;

  // The output register can take a new packet when it is empty or when the
  // FSB is draining it this cycle.
  assign load_en = ~out_v_reg | m_fsb_r_i;

  // An id is valid only when it selects an existing requester. Entries past
  // num_req_p can only occur when num_req_p is not a power of two.
  generate
    for (genvar gi = 0; gi < id_space_lp; gi++) begin : g_id_mask
      assign id_ok_mask[gi] = (gi < num_req_p);
    end
  endgenerate
  assign id_ok = id_ok_mask[credit_id_i];

  generate
    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_req
      assign req_data_arr[gi] = req_data_i[gi*fsb_width_p +: fsb_width_p];
      assign eligible[gi]     = req_v_i[gi] & (cnt_reg[gi] < cnt_width_lp'(max_credits_p));
      assign inc[gi]          = xfer & (winner == id_width_lp'(gi));
      assign dec[gi]          = credit_v_i & id_ok & (credit_id_i == id_width_lp'(gi));
      // Ready is gated by reset so that no handshake is offered while the
      // state is being cleared.
      assign req_r_o[gi]      = reset_n_i & inc[gi];
    end
  endgenerate

  // Round-robin scan. It starts one past the last grant, wraps at num_req_p,
  // and the first eligible index wins.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = last_grant_reg;
    for (int k = 0; k < num_req_p; k++) begin
      scan_idx = (scan_idx == id_width_lp'(num_req_p - 1)) ? '0 : scan_idx + id_width_lp'(1);
      if (!found && eligible[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // A transfer needs only a winner and a free output register. An eligible
  // winner already has its valid bit set.
  assign xfer = found & load_en;

  // A transfer and a credit return in the same cycle cancel each other. A
  // return to an empty counter leaves it at zero and raises the error.
  always_comb begin
    underflow = '0;
    for (int i = 0; i < num_req_p; i++) begin
      cnt_next[i] = cnt_reg[i];
      if (inc[i] && !dec[i]) begin
        cnt_next[i] = cnt_reg[i] + cnt_width_lp'(1);
      end else if (dec[i] && !inc[i]) begin
        if (cnt_reg[i] == '0) begin
          underflow[i] = 1'b1;
        end else begin
          cnt_next[i] = cnt_reg[i] - cnt_width_lp'(1);
        end
      end
    end
  end

  assign err_next = err_reg | (|underflow) | (credit_v_i & ~id_ok);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      out_v_reg      <= 1'b0;
      out_src_reg    <= '0;
      last_grant_reg <= id_width_lp'(num_req_p - 1);
      err_reg        <= 1'b0;
      for (int i = 0; i < num_req_p; i++) begin
        cnt_reg[i] <= '0;
      end
    end else begin
      if (load_en) begin
        out_v_reg <= found;
      end
      if (xfer) begin
        out_src_reg    <= winner;
        last_grant_reg <= winner;
      end
      err_reg <= err_next;
      for (int i = 0; i < num_req_p; i++) begin
        cnt_reg[i] <= cnt_next[i];
      end
    end
  end

  // The data path has no reset. Its content does not matter while the valid
  // bit is low.
  always_ff @(posedge clk_i) begin
    if (xfer) begin
      out_data_reg <= req_data_arr[winner];
    end
  end

  assign m_fsb_v_o    = out_v_reg;
  assign m_fsb_data_o = out_data_reg;
  assign m_fsb_src_o  = out_src_reg;
  assign credit_err_o = err_reg;

endmodule

// File: tb/tb_shared_fsb_tx_arbiter.sv
// Self-checking bench for shared_fsb_tx_arbiter with the default parameters.
// A negedge monitor keeps a behavioural model of grants, counters and the
// error flag. It checks req_r_o, m_fsb_v_o and credit_err_o every cycle. On
// each expected transfer it pushes the expected packet into a scoreboard. The
// head of the scoreboard is compared with the output register while it is
// valid. Each scenario task also makes its own direct checks.
module tb_shared_fsb_tx_arbiter;

  localparam int NUM  = 4;
  localparam int W    = 80;
  localparam int MAXC = 8;
  localparam int IDW  = 2;

  logic             clk;
  logic             reset_n;
  logic [NUM-1:0]   req_v;
  logic [NUM*W-1:0] req_data;
  logic [NUM-1:0]   req_r;
  logic             m_v;
  logic [W-1:0]     m_data;
  logic             m_r;
  logic [IDW-1:0]   m_src;
  logic             credit_v;
  logic [IDW-1:0]   credit_id;
  logic             credit_err;

  int tests_run    = 0;
  int tests_failed = 0;

  shared_fsb_tx_arbiter #(
    .num_req_p     (NUM),
    .fsb_width_p   (W),
    .max_credits_p (MAXC)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .req_v_i      (req_v),
    .req_data_i   (req_data),
    .req_r_o      (req_r),
    .m_fsb_v_o    (m_v),
    .m_fsb_data_o (m_data),
    .m_fsb_r_i    (m_r),
    .m_fsb_src_o  (m_src),
    .credit_v_i   (credit_v),
    .credit_id_i  (credit_id),
    .credit_err_o (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model + scoreboard ----------------
  logic [IDW+W-1:0] sb[$];
  logic             mdl_v;
  int               mdl_last;
  logic             mdl_err;
  int               mdl_cnt[NUM];
  logic             mon_en = 1'b0;
  logic             ml_load_en;
  logic             ml_found;
  int               ml_w;
  int               ml_idx;
  int               ml_inc;
  int               ml_cid;
  logic [NUM-1:0]   ml_exp_r;

  always @(negedge clk) begin
    if (!reset_n) begin
      tests_run++;
      if (req_r !== '0) begin
        tests_failed++;
        $display("FAIL mon_reset_ready: req_r_o=%b required 0000", req_r);
      end
      mdl_v    = 1'b0;
      mdl_last = NUM - 1;
      mdl_err  = 1'b0;
      foreach (mdl_cnt[i]) mdl_cnt[i] = 0;
      sb.delete();
      mon_en = 1'b1;
    end else if (mon_en) begin
      ml_load_en = !mdl_v || m_r;
      ml_found   = 1'b0;
      ml_w       = 0;
      for (int k = 1; k <= NUM; k++) begin
        ml_idx = (mdl_last + k) % NUM;
        if (!ml_found && req_v[ml_idx] && mdl_cnt[ml_idx] < MAXC) begin
          ml_found = 1'b1;
          ml_w     = ml_idx;
        end
      end
      ml_exp_r = (ml_found && ml_load_en) ? (NUM'(1) << ml_w) : '0;

      tests_run++;
      if (req_r !== ml_exp_r) begin
        tests_failed++;
        $display("FAIL mon_ready @%0t: req_r_o=%b required %b", $time, req_r, ml_exp_r);
      end
      tests_run++;
      if (m_v !== mdl_v) begin
        tests_failed++;
        $display("FAIL mon_valid @%0t: m_fsb_v_o=%b required %b", $time, m_v, mdl_v);
      end
      tests_run++;
      if (credit_err !== mdl_err) begin
        tests_failed++;
        $display("FAIL mon_err @%0t: credit_err_o=%b required %b", $time, credit_err, mdl_err);
      end

      if (mdl_v) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL mon_scoreboard @%0t: output valid but no packet expected", $time);
        end else begin
          if ({m_src, m_data} !== sb[0]) begin
            tests_failed++;
            $display("FAIL mon_packet @%0t: src=%0d data=%h required src=%0d data=%h",
                     $time, m_src, m_data, sb[0][IDW+W-1:W], sb[0][W-1:0]);
          end
          if (m_r) void'(sb.pop_front());
        end
      end

      ml_inc = -1;
      if (ml_found && ml_load_en) begin
        sb.push_back({IDW'(ml_w), req_data[ml_w*W +: W]});
        mdl_last = ml_w;
        ml_inc   = ml_w;
      end
      if (credit_v) begin
        ml_cid = int'(credit_id);
        if (ml_cid >= NUM) mdl_err = 1'b1;
        else if (ml_cid == ml_inc) ml_inc = -1;
        else if (mdl_cnt[ml_cid] == 0) mdl_err = 1'b1;
        else mdl_cnt[ml_cid]--;
      end
      if (ml_inc >= 0) mdl_cnt[ml_inc]++;
      if (ml_load_en) mdl_v = ml_found;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [NUM-1:0] v, input logic r, input logic cv, input int cid);
    logic [95:0] tmp;
    for (int i = 0; i < NUM; i++) begin
      tmp = {$urandom(), $urandom(), $urandom()};
      req_data[i*W +: W] = tmp[W-1:0];
    end
    req_v     = v;
    m_r       = r;
    credit_v  = cv;
    credit_id = IDW'(cid);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_inputs(4'hF, 1'b1, 1'b1, c);
      @(negedge clk);
      tests_run++;
      if (req_r !== 4'b0000) begin
        tests_failed++;
        $display("FAIL reset_ready: req_r_o=%b required 0000", req_r);
      end
      tick();
    end
    reset_n = 1'b1;
    set_inputs(4'h0, 1'b1, 1'b0, 0);
    @(negedge clk);
    tests_run++;
    if (m_v !== 1'b0 || m_src !== 2'd0 || credit_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: v=%b src=%0d err=%b required 0 0 0", m_v, m_src, credit_err);
    end
    $display("[TB] test_reset done");
    tick();
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 12; c++) begin
      set_inputs(4'hF, 1'b1, (c >= 1), (c + 3) % NUM);
      @(negedge clk);
      tests_run++;
      if (req_r !== 4'(1 << (c % NUM))) begin
        tests_failed++;
        $display("FAIL rr_grant c=%0d: req_r_o=%b required %b", c, req_r, 4'(1 << (c % NUM)));
      end
      if (c >= 1) begin
        tests_run++;
        if (m_v !== 1'b1 || m_src !== IDW'((c - 1) % NUM)) begin
          tests_failed++;
          $display("FAIL rr_src c=%0d: v=%b src=%0d required 1 %0d", c, m_v, m_src, (c - 1) % NUM);
        end
      end
      tick();
    end
    set_inputs(4'h0, 1'b1, 1'b1, 3);
    tick();
    set_inputs(4'h0, 1'b1, 1'b0, 0);
    tick();
    $display("[TB] test_round_robin done");
  endtask

  task automatic test_credit_limit();
    int acc;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      set_inputs(4'b0100, 1'b1, 1'b0, 0);
      @(negedge clk);
      if (req_r[2]) acc++;
      tick();
    end
    tests_run++;
    if (acc !== 8) begin
      tests_failed++;
      $display("FAIL limit_accepts: accepted=%0d required 8", acc);
    end
    set_inputs(4'b0100, 1'b1, 1'b0, 0);
    @(negedge clk);
    tests_run++;
    if (req_r !== 4'b0000) begin
      tests_failed++;
      $display("FAIL limit_blocked: req_r_o=%b required 0000", req_r);
    end
    tick();
    set_inputs(4'b0100, 1'b1, 1'b1, 2);
    @(negedge clk);
    tests_run++;
    if (req_r !== 4'b0000) begin
      tests_failed++;
      $display("FAIL limit_credit_same_cycle: req_r_o=%b required 0000", req_r);
    end
    tick();
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      set_inputs(4'b0100, 1'b1, 1'b0, 0);
      @(negedge clk);
      if (req_r[2]) acc++;
      tick();
    end
    tests_run++;
    if (acc !== 1) begin
      tests_failed++;
      $display("FAIL limit_one_more: accepted=%0d required 1", acc);
    end
    for (int c = 0; c < 8; c++) begin
      set_inputs(4'h0, 1'b1, 1'b1, 2);
      tick();
    end
    set_inputs(4'h0, 1'b1, 1'b0, 0);
    tick();
    $display("[TB] test_credit_limit done");
  endtask

  task automatic test_backpressure();
    logic [W-1:0] hold;
    set_inputs(4'b0010, 1'b1, 1'b0, 0);
    hold = req_data[1*W +: W];
    @(negedge clk);
    tests_run++;
    if (req_r !== 4'b0010) begin
      tests_failed++;
      $display("FAIL bp_first_grant: req_r_o=%b required 0010", req_r);
    end
    tick();
    for (int c = 0; c < 5; c++) begin
      set_inputs(4'hF, 1'b0, 1'b0, 0);
      @(negedge clk);
      tests_run++;
      if (m_v !== 1'b1 || m_src !== 2'd1 || m_data !== hold || req_r !== 4'b0000) begin
        tests_failed++;
        $display("FAIL bp_hold c=%0d: v=%b src=%0d data=%h rdy=%b required 1 1 %h 0000",
                 c, m_v, m_src, m_data, req_r, hold);
      end
      tick();
    end
    set_inputs(4'hF, 1'b1, 1'b0, 0);
    @(negedge clk);
    tests_run++;
    if (req_r !== 4'b0100) begin
      tests_failed++;
      $display("FAIL bp_release_grant: req_r_o=%b required 0100", req_r);
    end
    tick();
    set_inputs(4'h0, 1'b1, 1'b0, 0);
    @(negedge clk);
    tests_run++;
    if (m_v !== 1'b1 || m_src !== 2'd2) begin
      tests_failed++;
      $display("FAIL bp_next_src: v=%b src=%0d required 1 2", m_v, m_src);
    end
    tick();
    set_inputs(4'h0, 1'b1, 1'b1, 1);
    tick();
    set_inputs(4'h0, 1'b1, 1'b1, 2);
    tick();
    set_inputs(4'h0, 1'b1, 1'b0, 0);
    tick();
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_credit_underflow();
    int acc;
    set_inputs(4'h0, 1'b1, 1'b1, 3);
    @(negedge clk);
    tests_run++;
    if (credit_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL uf_before: credit_err_o=%b required 0", credit_err);
    end
    tick();
    set_inputs(4'h0, 1'b1, 1'b0, 0);
    @(negedge clk);
    tests_run++;
    if (credit_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL uf_set: credit_err_o=%b required 1", credit_err);
    end
    tick();
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      set_inputs(4'b1000, 1'b1, 1'b0, 0);
      @(negedge clk);
      if (req_r[3]) acc++;
      tick();
    end
    tests_run++;
    if (acc !== 8) begin
      tests_failed++;
      $display("FAIL uf_count_zero: accepted=%0d required 8", acc);
    end
    for (int c = 0; c < 8; c++) begin
      set_inputs(4'h0, 1'b1, 1'b1, 3);
      tick();
    end
    set_inputs(4'h0, 1'b1, 1'b0, 0);
    @(negedge clk);
    tests_run++;
    if (credit_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL uf_sticky: credit_err_o=%b required 1", credit_err);
    end
    tick();
    $display("[TB] test_credit_underflow done");
  endtask

  task automatic test_simultaneous();
    int acc;
    for (int c = 0; c < 5; c++) begin
      set_inputs(4'b0001, 1'b1, 1'b0, 0);
      tick();
    end
    set_inputs(4'b0001, 1'b1, 1'b1, 0);
    @(negedge clk);
    tests_run++;
    if (req_r !== 4'b0001) begin
      tests_failed++;
      $display("FAIL sim_grant: req_r_o=%b required 0001", req_r);
    end
    tick();
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      set_inputs(4'b0001, 1'b1, 1'b0, 0);
      @(negedge clk);
      if (req_r[0]) acc++;
      tick();
    end
    tests_run++;
    if (acc !== 3) begin
      tests_failed++;
      $display("FAIL sim_count_kept: accepted=%0d required 3", acc);
    end
    $display("[TB] test_simultaneous done");
  endtask

  task automatic test_reset_mid();
    int acc[NUM];
    set_inputs(4'b0010, 1'b1, 1'b0, 0);
    @(negedge clk);
    tests_run++;
    if (req_r !== 4'b0010) begin
      tests_failed++;
      $display("FAIL rst_mid_grant: req_r_o=%b required 0010", req_r);
    end
    tick();
    set_inputs(4'hF, 1'b0, 1'b0, 0);
    @(negedge clk);
    tests_run++;
    if (m_v !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_pending: m_fsb_v_o=%b required 1", m_v);
    end
    tick();
    reset_n = 1'b0;
    set_inputs(4'hF, 1'b0, 1'b0, 0);
    tick();
    reset_n = 1'b1;
    foreach (acc[i]) acc[i] = 0;
    for (int c = 0; c < 40; c++) begin
      set_inputs(4'hF, 1'b1, 1'b0, 0);
      @(negedge clk);
      if (c == 0) begin
        tests_run++;
        if (m_v !== 1'b0 || credit_err !== 1'b0 || req_r !== 4'b0001) begin
          tests_failed++;
          $display("FAIL rst_mid_after: v=%b err=%b rdy=%b required 0 0 0001", m_v, credit_err, req_r);
        end
      end
      for (int i = 0; i < NUM; i++) if (req_r[i]) acc[i]++;
      tick();
    end
    for (int i = 0; i < NUM; i++) begin
      tests_run++;
      if (acc[i] !== MAXC) begin
        tests_failed++;
        $display("FAIL rst_mid_counts req%0d: accepted=%0d required %0d", i, acc[i], MAXC);
      end
    end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    reset_n = 1'b0;
    set_inputs(4'h0, 1'b0, 1'b0, 0);
    test_reset();
    test_round_robin();
    test_credit_limit();
    test_backpressure();
    test_credit_underflow();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shared_fsb_tx_arbiter.md
SHARED_FSB_TX_ARBITER -- requirements
Module: shared_fsb_tx_arbiter

Interface
REQ-001 SHALL have parameter num_req_p, default 4, number of requesters sharing the FSB master port (2..8).
REQ-002 SHALL have parameter fsb_width_p, default 80, FSB packet width in bits.
REQ-003 SHALL have parameter max_credits_p, default 8, maximum outstanding packets per requester (1..15).
REQ-004 SHALL have parameter id_width_lp, derived as ceil(log2(num_req_p)), not overridden.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n_i, input, 1, synchronous active-low reset.
REQ-007 SHALL have port req_v_i, input, num_req_p, per-requester packet valid.
REQ-008 SHALL have port req_data_i, input, num_req_p*fsb_width_p, per-requester packet; requester i occupies bits [i*fsb_width_p +: fsb_width_p].
REQ-009 SHALL have port req_r_o, output, num_req_p, per-requester ready; a transfer occurs when req_v_i[i] & req_r_o[i].
REQ-010 SHALL have port m_fsb_v_o, output, 1, FSB master valid.
REQ-011 SHALL have port m_fsb_data_o, output, fsb_width_p, FSB master packet.
REQ-012 SHALL have port m_fsb_r_i, input, 1, FSB master ready.
REQ-013 SHALL have port m_fsb_src_o, output, id_width_lp, requester index of the packet on m_fsb_data_o.
REQ-014 SHALL have port credit_v_i, input, 1, one credit returned this cycle.
REQ-015 SHALL have port credit_id_i, input, id_width_lp, requester receiving the returned credit.
REQ-016 SHALL have port credit_err_o, output, 1, sticky flag set on credit underflow or an out-of-range credit_id_i.

Function
REQ-017 SHALL hold one output register (valid bit, data, src); load_en = ~m_fsb_v_o | m_fsb_r_i.
REQ-018 SHALL treat requester i as eligible when req_v_i[i]=1 and its outstanding count < max_credits_p.
REQ-019 SHALL grant round-robin: scan starts at last_grant+1 modulo num_req_p; the first eligible index wins.
REQ-020 SHALL assert req_r_o[i] only for the winner and only when load_en=1; at most one bit of req_r_o is set per cycle.
REQ-021 SHALL, on a transfer, load winner data/index into the output register next cycle (1-cycle latency) and set last_grant to the winner.
REQ-022 SHALL keep last_grant unchanged in cycles with no transfer.
REQ-023 SHALL, when load_en=1 and no requester is eligible, clear m_fsb_v_o next cycle.
REQ-024 SHALL keep m_fsb_data_o and m_fsb_src_o stable while m_fsb_v_o=1 and m_fsb_r_i=0.
REQ-025 SHALL sustain one packet per cycle when m_fsb_r_i is held at 1.
REQ-026 SHALL keep one counter per requester, each ceil(log2(max_credits_p+1)) bits: +1 on that requester's transfer, -1 on credit_v_i with a matching credit_id_i.
REQ-027 SHALL leave a counter unchanged when its increment and decrement occur in the same cycle.
REQ-028 SHALL, on a credit return to a counter at 0 with no same-cycle transfer, leave that counter at 0 and set credit_err_o.
REQ-029 SHALL, on credit_id_i >= num_req_p, ignore the return and set credit_err_o.
REQ-030 SHALL never let a counter exceed max_credits_p; the eligibility rule guarantees this.
REQ-031 SHALL make the updated counter value affect eligibility from the next cycle on.

Reset
REQ-032 SHALL, while reset_n_i=0 at a clock edge, clear m_fsb_v_o, m_fsb_src_o, every counter and credit_err_o, and set last_grant = num_req_p-1 (index 0 has first priority).
REQ-033 SHALL drive req_r_o to 0 during reset.
REQ-034 SHALL, on reset mid-transfer, discard the packet in the output register and all credit state; m_fsb_data_o content is don't-care while m_fsb_v_o=0.

Verification
REQ-035 All 4 requesters valid continuously, m_fsb_r_i=1, credits returned each cycle -> m_fsb_src_o sequence 0,1,2,3,0,..., one packet per cycle.
REQ-036 Requester 2 alone sends 8 packets, no credits returned -> 8 packets forwarded, then req_r_o[2]=0; one credit_v_i with id 2 -> exactly one more packet is accepted.
REQ-037 m_fsb_r_i=0 for 5 cycles while holding packet from requester 1 -> m_fsb_v_o=1 and data/src unchanged; no req_r_o asserted; on release the next grant goes to requester 2.
REQ-038 Credit return to requester 3 at count 0 -> credit_err_o=1 from the next cycle and stays set until reset; counter stays 0.
REQ-039 Requester 0 transfers in the same cycle as credit_v_i with id 0 while its count is 5 -> count stays 5.
REQ-040 reset_n_i=0 for 1 cycle while m_fsb_v_o=1 and counts are nonzero -> m_fsb_v_o=0, all counts 0 and credit_err_o=0; the first grant after reset goes to requester 0.
